gate_tt_sequencer: RTL and testbench

//  Sequencer that drives a combinational gate-under-test (e.g. the 3-input AND gate) through every

---
 rtl/gate_tb_pkg.sv | 16 +
 rtl/gate_tt_checker.sv | 21 ++
 rtl/gate_tt_sequencer.sv | 117 +++++++++++
 tb/tb_gate_tt_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gate_tb_pkg.sv
// gate_tb_pkg: shared state encoding, vector-count helper and canonical 3-input truth tables
package gate_tb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;
  localparam logic [7:0] AND3_TT = 8'h80;
  localparam logic [7:0] OR3_TT  = 8'hFE;
  localparam logic [7:0] XOR3_TT = 8'h96;
  function automatic int n_vec(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: compares one sampled gate output with its expected bit and updates the error tally
module gate_tt_checker #(
  parameter int N_IN = 3
) (
  input  logic            i_exp,
  input  logic            i_obs,
  input  logic [N_IN-1:0] i_idx,
  input  logic [N_IN:0]   i_err_count,
  input  logic [N_IN-1:0] i_first_fail,
  input  logic            i_fail_seen,
  output logic [N_IN:0]   o_err_count,
  output logic [N_IN-1:0] o_first_fail,
  output logic            o_fail_seen
);
  logic w_mismatch;
  assign w_mismatch   = i_exp ^ i_obs;
  assign o_err_count  = i_err_count + {{N_IN{1'b0}}, w_mismatch};
  // vectors are visited in ascending order, so the first recorded mismatch is the lowest index
  assign o_first_fail = (w_mismatch && !i_fail_seen) ? i_idx : i_first_fail;
  assign o_fail_seen  = i_fail_seen | w_mismatch;
endmodule

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: sweeps a gate through all input vectors and checks it against a latched truth table
module gate_tt_sequencer
  import gate_tb_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [n_vec(N_IN)-1:0]   expected,
  input  logic                     dut_out,
  output logic [N_IN-1:0]          dut_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_count,
  output logic [N_IN-1:0]          first_fail,
  output logic                     fail_seen,
  output logic [n_vec(N_IN)-1:0]   observed
);
  localparam int NV = n_vec(N_IN);
  localparam int SCW = $clog2(SETTLE_CYC + 2);
  localparam logic [N_IN-1:0] LAST_IDX = '1;
  state_t r_state, w_next;
  logic [NV-1:0]   r_exp, r_obs;
  logic [N_IN-1:0] r_idx, r_dut_in, r_first_fail;
  logic [N_IN:0]   r_err_count;
  logic [SCW-1:0]  r_cnt;
  logic            r_done, r_pass, r_fail_seen;
  logic [N_IN:0]   w_err_count;
  logic [N_IN-1:0] w_first_fail;
  logic            w_fail_seen, w_last;
  assign w_last = r_idx == LAST_IDX;
  gate_tt_checker #(.N_IN(N_IN)) u_chk (
    .i_exp        (r_exp[r_idx]),
    .i_obs        (dut_out),
    .i_idx        (r_idx),
    .i_err_count  (r_err_count),
    .i_first_fail (r_first_fail),
    .i_fail_seen  (r_fail_seen),
    .o_err_count  (w_err_count),
    .o_first_fail (w_first_fail),
    .o_fail_seen  (w_fail_seen)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state: abort overrides everything, start only honoured when not mid-sweep
  always_comb begin
    w_next = r_state;
    if (abort) w_next = ST_IDLE;
    else
      case (r_state)
        ST_IDLE, ST_DONE: w_next = start ? ST_APPLY : r_state;
        ST_APPLY:         w_next = (SETTLE_CYC > 0) ? ST_SETTLE : ST_SAMPLE;
        ST_SETTLE:        w_next = (r_cnt == SCW'(1)) ? ST_SAMPLE : ST_SETTLE;
        ST_SAMPLE:        w_next = w_last ? ST_DONE : ST_APPLY;
        default:          w_next = ST_IDLE;
      endcase
  end
  // datapath: vector drive, settle timing and result capture; abort freezes everything as-is
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_exp        <= '0;
      r_obs        <= '0;
      r_idx        <= '0;
      r_dut_in     <= '0;
      r_first_fail <= '0;
      r_err_count  <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_seen  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!abort)
        case (r_state)
          ST_IDLE, ST_DONE:
            if (start) begin
              r_exp        <= expected;
              r_obs        <= '0;
              r_idx        <= '0;
              r_first_fail <= '0;
              r_err_count  <= '0;
              r_pass       <= 1'b0;
              r_fail_seen  <= 1'b0;
            end
          ST_APPLY: begin
            r_dut_in <= r_idx;
            r_cnt    <= SCW'(SETTLE_CYC);
          end
          ST_SETTLE: r_cnt <= r_cnt - SCW'(1);
          ST_SAMPLE: begin
            r_obs[r_idx] <= dut_out;
            r_err_count  <= w_err_count;
            r_first_fail <= w_first_fail;
            r_fail_seen  <= w_fail_seen;
            if (w_last) begin
              r_done <= 1'b1;
              r_pass <= w_err_count == '0;
            end else r_idx <= r_idx + 1'b1;
          end
          default: ;
        endcase
    end
  assign dut_in     = r_dut_in;
  assign busy       = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign first_fail = r_first_fail;
  assign fail_seen  = r_fail_seen;
  assign observed   = r_obs;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// tb_gate_tt_sequencer: drives sweeps on AND3 gates (settle 1 and settle 0) and scores the results
module tb_gate_tt_sequencer;
  import gate_tb_pkg::*;
  typedef struct {
    logic [7:0] obs;
    logic [3:0] err;
    logic [2:0] ff;
    logic       fs;
    logic       pass;
    int         cyc;
  } res_t;
  logic clk, rst_n, start, abort, sel;
  logic [7:0] expected;
  logic [2:0] dut_in1, dut_in0, first_fail1, first_fail0;
  logic [3:0] err_count1, err_count0;
  logic [7:0] observed1, observed0;
  logic busy1, busy0, done1, done0, pass1, pass0, fs1, fs0;
  logic g1, g0;
  logic [2:0] dut_in_m, ff_m;
  logic [3:0] err_m;
  logic [7:0] obs_m;
  logic busy_m, done_m, pass_m, fs_m;
  res_t sb[$];
  int n_chk = 0, n_pass = 0;
  assign g1 = &dut_in1;
  assign g0 = &dut_in0;
  assign dut_in_m = sel ? dut_in0 : dut_in1;
  assign ff_m     = sel ? first_fail0 : first_fail1;
  assign err_m    = sel ? err_count0 : err_count1;
  assign obs_m    = sel ? observed0 : observed1;
  assign busy_m   = sel ? busy0 : busy1;
  assign done_m   = sel ? done0 : done1;
  assign pass_m   = sel ? pass0 : pass1;
  assign fs_m     = sel ? fs0 : fs1;
  gate_tt_sequencer #(.N_IN(3), .SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort), .expected(expected),
    .dut_out(g1), .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .first_fail(first_fail1), .fail_seen(fs1), .observed(observed1)
  );
  gate_tt_sequencer #(.N_IN(3), .SETTLE_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort), .expected(expected),
    .dut_out(g0), .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .first_fail(first_fail0), .fail_seen(fs0), .observed(observed0)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic res_t model(input logic [7:0] e, input int cyc);
    res_t m;
    m.obs = '0; m.err = '0; m.ff = '0; m.fs = 1'b0; m.cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      m.obs[i] = &v;
      if (m.obs[i] !== e[i]) begin
        m.err++;
        if (!m.fs) begin m.ff = v; m.fs = 1'b1; end
      end
    end
    m.pass = m.err == 0;
    return m;
  endfunction
  // called at a negedge; abort_at/restart_at are cycle numbers after start accept (0 = unused)
  task automatic sweep(input logic [7:0] e, input bit s0, input int abort_at, input int restart_at);
    int cyc, bad, per, dn;
    logic [2:0] want;
    res_t r;
    sel = s0;
    per = s0 ? 2 : 3;
    expected = e;
    start = 1'b1;
    if (abort_at == 0) sb.push_back(model(e, 8 * per));
    @(negedge clk);
    start = 1'b0;
    expected = ~e;
    cyc = 1;
    bad = 0;
    while (cyc < 200) begin
      if (done_m) break;
      want = 3'((cyc - 2) / per);
      if (cyc >= 2 && dut_in_m !== want) bad++;
      start = cyc == restart_at;
      abort = cyc == abort_at;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (abort_at != 0 && cyc > abort_at) break;
    end
    check("dut_in_seq", bad, 0);
    if (abort_at != 0) begin
      check("abort_busy", busy_m, 0);
      check("abort_done", done_m, 0);
      dn = 0;
      repeat (40) begin @(negedge clk); if (done_m) dn++; end
      check("abort_no_done", dn, 0);
      check("abort_pass", pass_m, 0);
      check("abort_busy_late", busy_m, 0);
    end else begin
      r = sb.pop_front();
      check("sweep_cycles", cyc - 1, r.cyc);
      check("pass", pass_m, r.pass);
      check("err_count", err_m, r.err);
      check("first_fail", ff_m, r.ff);
      check("fail_seen", fs_m, r.fs);
      check("observed", obs_m, r.obs);
      check("busy_at_done", busy_m, 0);
      @(negedge clk);
      check("done_one_cycle", done_m, 0);
      check("pass_held", pass_m, r.pass);
    end
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; expected = '0;
    #12;
    check("rst_dut_in", dut_in_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_err", err_m, 0);
    check("rst_obs", obs_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(AND3_TT, 1'b0, 0, 0);
    sweep(8'h81, 1'b0, 0, 0);
    sweep(8'h00, 1'b0, 0, 0);
    sweep(AND3_TT, 1'b0, 0, 0);
    sweep(AND3_TT, 1'b0, 10, 0);
    sweep(OR3_TT, 1'b0, 0, 5);
    sweep(XOR3_TT, 1'b0, 0, 0);
    sel = 1'b0;
    expected = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_fs", fs_m, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dut_in", dut_in_m, 0);
    check("arst_busy", busy_m, 0);
    check("arst_err", err_m, 0);
    check("arst_fs", fs_m, 0);
    check("arst_obs", obs_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(AND3_TT, 1'b0, 0, 0);
    sweep(AND3_TT, 1'b1, 0, 0);
    sweep(8'h01, 1'b1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
